// File: rtl/msx_pkg.sv
// Shared definitions for the MSX slot controller: I/O and memory decode
// constants, slot/page types, the M1 wait FSM state encoding and a small
// helper that extracts a 2-bit slot field for a page.
package msx_pkg;

    localparam logic [7:0]  PSR_PORT = 8'hA8;
    localparam logic [15:0] SSR_ADDR = 16'hFFFF;

    typedef logic [1:0] slot_t;
    typedef logic [1:0] page_t;

    typedef enum logic [1:0] {
        WS_IDLE = 2'b00,
        WS_WAIT = 2'b01,
        WS_DONE = 2'b10
    } wait_state_e;

    // Return the 2-bit slot field for page p from a packed 4x2 slot register.
    function automatic slot_t slot_field(input logic [7:0] reg_v, input page_t p);
        slot_t res;
        res = reg_v[{p, 1'b0} +: 2];
        return res;
    endfunction

endpackage

// File: rtl/msx_m1_wait.sv
// One-wait-state generator for Z80 opcode fetches. wait_n is registered and
// drops for exactly one enabled tick per M1 memory cycle; it is re-armed
// only after m1_n is sampled high, so long fetches cannot wait twice.
module msx_m1_wait
    import msx_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic clk_en_3m58_p,
    input  logic m1_n,
    input  logic mreq_n,
    input  logic rfsh_n,
    input  logic iorq_n,
    output logic wait_n
);

    wait_state_e state_q;
    logic        wait_n_q;
    logic        fetch_s;

    // A qualifying fetch: M1 with a memory request, not refresh, not int-ack.
    always_comb begin
        fetch_s = 1'b0;
        if (!m1_n && !mreq_n && rfsh_n && iorq_n) begin
            fetch_s = 1'b1;
        end else begin
            fetch_s = 1'b0;
        end
    end

    // Wait FSM with registered wait_n; advances only on enabled CPU ticks.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= WS_IDLE;
            wait_n_q <= 1'b1;
        end else if (clk_en_3m58_p) begin
            case (state_q)
                WS_IDLE: begin
                    if (fetch_s) begin
                        state_q  <= WS_WAIT;
                        wait_n_q <= 1'b0;
                    end else begin
                        state_q  <= WS_IDLE;
                        wait_n_q <= 1'b1;
                    end
                end
                WS_WAIT: begin
                    state_q  <= WS_DONE;
                    wait_n_q <= 1'b1;
                end
                WS_DONE: begin
                    wait_n_q <= 1'b1;
                    if (m1_n) begin
                        state_q <= WS_IDLE;
                    end else begin
                        state_q <= WS_DONE;
                    end
                end
                default: begin
                    state_q  <= WS_IDLE;
                    wait_n_q <= 1'b1;
                end
            endcase
        end
    end

    assign wait_n = wait_n_q;

endmodule

// File: rtl/msx_slot_ctrl.sv
// MSX primary/secondary slot controller. Holds the primary slot register at
// I/O port A8h, decodes the current page into a primary slot and inserts one
// wait state per opcode fetch. Optional feature macro MSX_SUBSLOT_EN adds the
// secondary slot registers at memory FFFFh for slots flagged in EXPANDED_MASK.
module msx_slot_ctrl
    import msx_pkg::*;
#(
    parameter logic [3:0] EXPANDED_MASK = 4'b1000
)
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clk_en_3m58_p,
    input  logic [15:0] a,
    input  logic [7:0]  d_from_cpu,
    input  logic        mreq_n,
    input  logic        iorq_n,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic        m1_n,
    input  logic        rfsh_n,
    output logic        wait_n,
    output logic [7:0]  d_out,
    output logic        d_oe,
    output logic [1:0]  prim_slot,
    output logic [1:0]  sec_slot,
    output logic [1:0]  page
);

    logic [7:0] psr_q;
    logic [7:0] psr_d;
    logic       psr_wr_done_q;
    logic       psr_wr_done_d;
    logic       psr_hit_s;
    logic       psr_wr_s;
    logic       psr_rd_s;
    page_t      page_s;
    slot_t      prim_slot_s;
    logic       ssr_rd_s;
    logic [7:0] ssr_rd_data_s;
    slot_t      sec_slot_s;

    assign page_s      = a[15:14];
    assign prim_slot_s = slot_field(psr_q, page_s);

    // Decode of the primary slot port; M1 must be high so int-ack never hits.
    always_comb begin
        psr_hit_s = 1'b0;
        if (!iorq_n && m1_n && (a[7:0] == PSR_PORT)) begin
            psr_hit_s = 1'b1;
        end else begin
            psr_hit_s = 1'b0;
        end
    end

    assign psr_wr_s = psr_hit_s && !wr_n;
    assign psr_rd_s = psr_hit_s && !rd_n;

    // PSR next state: latch once per I/O cycle, re-arm when iorq_n goes high.
    always_comb begin
        psr_d         = psr_q;
        psr_wr_done_d = psr_wr_done_q;
        if (iorq_n) begin
            psr_wr_done_d = 1'b0;
        end else if (psr_wr_s && !psr_wr_done_q) begin
            psr_d         = d_from_cpu;
            psr_wr_done_d = 1'b1;
        end else begin
            psr_d         = psr_q;
            psr_wr_done_d = psr_wr_done_q;
        end
    end

    // PSR storage, updated on enabled CPU ticks only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            psr_q         <= 8'h00;
            psr_wr_done_q <= 1'b0;
        end else if (clk_en_3m58_p) begin
            psr_q         <= psr_d;
            psr_wr_done_q <= psr_wr_done_d;
        end
    end

`ifdef MSX_SUBSLOT_EN
    logic [7:0] ssr_q [4];
    logic       ssr_wr_done_q;
    logic       ssr_hit_s;
    logic       ssr_wr_s;
    slot_t      ssr_sel_s;

    assign ssr_sel_s = psr_q[7:6];

    // FFFFh decode, only for a page-3 slot marked as expanded.
    always_comb begin
        ssr_hit_s = 1'b0;
        if (!mreq_n && rfsh_n && (a == SSR_ADDR) && EXPANDED_MASK[ssr_sel_s]) begin
            ssr_hit_s = 1'b1;
        end else begin
            ssr_hit_s = 1'b0;
        end
    end

    assign ssr_wr_s      = ssr_hit_s && !wr_n;
    assign ssr_rd_s      = ssr_hit_s && !rd_n;
    assign ssr_rd_data_s = ~ssr_q[ssr_sel_s];

    // Secondary slot registers: one write per memory cycle, re-armed on mreq_n high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                ssr_q[i] <= 8'h00;
            end
            ssr_wr_done_q <= 1'b0;
        end else if (clk_en_3m58_p) begin
            if (mreq_n) begin
                ssr_wr_done_q <= 1'b0;
            end else if (ssr_wr_s && !ssr_wr_done_q) begin
                ssr_q[ssr_sel_s] <= d_from_cpu;
                ssr_wr_done_q    <= 1'b1;
            end else begin
                ssr_wr_done_q <= ssr_wr_done_q;
            end
        end
    end

    // Secondary slot for the current page, zero for non-expanded slots.
    always_comb begin
        sec_slot_s = 2'b00;
        if (EXPANDED_MASK[prim_slot_s]) begin
            sec_slot_s = slot_field(ssr_q[prim_slot_s], page_s);
        end else begin
            sec_slot_s = 2'b00;
        end
    end
`else
    logic unused_cfg_s;

    assign ssr_rd_s      = 1'b0;
    assign ssr_rd_data_s = 8'h00;
    assign sec_slot_s    = 2'b00;
    assign unused_cfg_s  = ^{EXPANDED_MASK, a[13:8]};
`endif

    // Read data mux; idle bus drives zero with the output enable low.
    always_comb begin
        d_oe  = 1'b0;
        d_out = 8'h00;
        if (psr_rd_s) begin
            d_oe  = 1'b1;
            d_out = psr_q;
        end else if (ssr_rd_s) begin
            d_oe  = 1'b1;
            d_out = ssr_rd_data_s;
        end else begin
            d_oe  = 1'b0;
            d_out = 8'h00;
        end
    end

    assign prim_slot = prim_slot_s;
    assign sec_slot  = sec_slot_s;
    assign page      = page_s;

    msx_m1_wait u_m1_wait (
        .clk           (clk),
        .reset_n       (reset_n),
        .clk_en_3m58_p (clk_en_3m58_p),
        .m1_n          (m1_n),
        .mreq_n        (mreq_n),
        .rfsh_n        (rfsh_n),
        .iorq_n        (iorq_n),
        .wait_n        (wait_n)
    );

endmodule
